// File: rtl/icu_nway_ctrl.sv
// N-way set-associative instruction-cache controller between the IFU (ic1/ic2) and the BIU.
// The tag and data RAMs are external and synchronous with a 1-cycle read latency.
// Fetch acknowledge and response outputs are combinational, so a hit is returned one cycle after acceptance.
module icu_nway_ctrl #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned IDX   = 7,
  parameter int unsigned BEATS = 4
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  logic                                          ifu_icu_req_ic1,
  input  logic [31:3]                                   ifu_icu_addr_ic1,
  output logic                                          icu_ifu_ack_ic1,
  input  logic                                          ifu_icu_cancel,
  input  logic                                          ifu_icu_flush,
  output logic                                          icu_ifu_flush_done,
  output logic                                          icu_ifu_data_valid_ic2,
  output logic [63:0]                                   icu_ifu_data_ic2,
  output logic                                          icu_ifu_fault_ic2,
  output logic [WAYS-1:0]                               icu_ram_tag_en,
  output logic                                          icu_ram_tag_wr,
  output logic [IDX-1:0]                                icu_ram_tag_addr,
  output logic [29-$clog2(BEATS)-IDX:0]                 icu_ram_tag_wdata,
  input  logic [WAYS*(30-$clog2(BEATS)-IDX)-1:0]        ram_icu_tag_rdata,
  output logic [WAYS-1:0]                               icu_ram_data_en,
  output logic                                          icu_ram_data_wr,
  output logic [IDX+$clog2(BEATS)-1:0]                  icu_ram_data_addr,
  output logic [63:0]                                   icu_ram_data_wdata,
  input  logic [WAYS*64-1:0]                            ram_icu_data_rdata,
  output logic                                          icu_biu_req,
  output logic [31:3]                                   icu_biu_addr,
  output logic                                          icu_biu_single,
  input  logic                                          biu_icu_ack,
  input  logic                                          biu_icu_data_valid,
  input  logic                                          biu_icu_data_last,
  input  logic                                          biu_icu_fault,
  input  logic [63:0]                                   biu_icu_data
);

  localparam int unsigned OFF  = $clog2(BEATS);
  localparam int unsigned TAGW = 29 - OFF - IDX;
  localparam int unsigned TW   = TAGW + 1;
  localparam int unsigned WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned SETS = 2 ** IDX;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_FILL   = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [31:3]     addr_q, addr_d;
  logic            flush_pend_q, flush_pend_d;
  logic [WW-1:0]   rr_q, rr_d;
  logic [WW-1:0]   victim_q, victim_d;
  logic [OFF-1:0]  beat_q, beat_d;
  logic            line_fault_q, line_fault_d;
  logic            cancel_q, cancel_d;
  logic [IDX-1:0]  flush_cnt_q, flush_cnt_d;

  logic [TAGW-1:0] tag_f;
  logic [IDX-1:0]  idx_f;
  logic [OFF-1:0]  rbeat_f;
  logic            hit_any;
  logic [63:0]     hit_data;
  logic            inv_any;
  logic [WW-1:0]   inv_way;
  logic [WAYS-1:0] victim_oh;
  logic            cancel_now;

  // Fields of the latched fetch address
  assign tag_f      = addr_q[31:3+OFF+IDX];
  assign idx_f      = addr_q[2+OFF+IDX:3+OFF];
  assign rbeat_f    = addr_q[2+OFF:3];
  assign victim_oh  = WAYS'(1) << victim_q;
  assign cancel_now = cancel_q | ifu_icu_cancel;

  // Tag compare across ways: lowest hitting way and lowest invalid way win
  always_comb begin
    hit_any  = 1'b0;
    hit_data = '0;
    inv_any  = 1'b0;
    inv_way  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit_any && ram_icu_tag_rdata[w*TW + TAGW] &&
          (ram_icu_tag_rdata[w*TW +: TAGW] == tag_f)) begin
        hit_any  = 1'b1;
        hit_data = ram_icu_data_rdata[w*64 +: 64];
      end
      if (!inv_any && !ram_icu_tag_rdata[w*TW + TAGW]) begin
        inv_any = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d                = state_q;
    addr_d                 = addr_q;
    flush_pend_d           = flush_pend_q;
    rr_d                   = rr_q;
    victim_d               = victim_q;
    beat_d                 = beat_q;
    line_fault_d           = line_fault_q;
    cancel_d               = cancel_q;
    flush_cnt_d            = flush_cnt_q;
    icu_ifu_ack_ic1        = 1'b0;
    icu_ifu_flush_done     = 1'b0;
    icu_ifu_data_valid_ic2 = 1'b0;
    icu_ifu_data_ic2       = '0;
    icu_ifu_fault_ic2      = 1'b0;
    icu_ram_tag_en         = '0;
    icu_ram_tag_wr         = 1'b0;
    icu_ram_tag_addr       = '0;
    icu_ram_tag_wdata      = '0;
    icu_ram_data_en        = '0;
    icu_ram_data_wr        = 1'b0;
    icu_ram_data_addr      = '0;
    icu_ram_data_wdata     = '0;
    icu_biu_req            = 1'b0;
    icu_biu_addr           = '0;
    icu_biu_single         = 1'b0;

    // A flush that arrives mid-transaction is remembered until the controller is idle
    if (ifu_icu_flush && (state_q != S_IDLE) && (state_q != S_FLUSH)) begin
      flush_pend_d = 1'b1;
    end
    if ((state_q == S_LOOKUP) || (state_q == S_MISS) || (state_q == S_FILL)) begin
      cancel_d = cancel_now;
    end

    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (ifu_icu_flush || flush_pend_q) begin
          flush_cnt_d = '0;
          state_d     = S_FLUSH;
        end else if (ifu_icu_req_ic1) begin
          icu_ifu_ack_ic1   = 1'b1;
          icu_ram_tag_en    = '1;
          icu_ram_data_en   = '1;
          icu_ram_tag_addr  = ifu_icu_addr_ic1[2+OFF+IDX:3+OFF];
          icu_ram_data_addr = ifu_icu_addr_ic1[2+OFF+IDX:3];
          addr_d            = ifu_icu_addr_ic1;
          state_d           = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any) begin
          icu_ifu_data_valid_ic2 = ~cancel_now;
          icu_ifu_data_ic2       = hit_data;
          state_d                = S_IDLE;
        end else begin
          victim_d = inv_any ? inv_way : rr_q;
          state_d  = S_MISS;
        end
      end
      S_MISS: begin
        icu_biu_req  = 1'b1;
        icu_biu_addr = {addr_q[31:3+OFF], OFF'(0)};
        if (biu_icu_ack) begin
          beat_d       = '0;
          line_fault_d = 1'b0;
          state_d      = S_FILL;
        end
      end
      S_FILL: begin
        if (biu_icu_data_valid) begin
          icu_ram_data_en    = victim_oh;
          icu_ram_data_wr    = 1'b1;
          icu_ram_data_addr  = {idx_f, beat_q};
          icu_ram_data_wdata = biu_icu_data;
          beat_d             = beat_q + OFF'(1);
          if (biu_icu_fault) begin
            line_fault_d = 1'b1;
          end
          if (beat_q == rbeat_f) begin
            icu_ifu_data_valid_ic2 = ~cancel_now;
            icu_ifu_data_ic2       = biu_icu_data;
            icu_ifu_fault_ic2      = biu_icu_fault;
          end
          if (biu_icu_data_last) begin
            icu_ram_tag_en    = victim_oh;
            icu_ram_tag_wr    = 1'b1;
            icu_ram_tag_addr  = idx_f;
            icu_ram_tag_wdata = {~(line_fault_q | biu_icu_fault), tag_f};
            rr_d              = rr_q + WW'(1);
            state_d           = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        icu_ram_tag_en   = '1;
        icu_ram_tag_wr   = 1'b1;
        icu_ram_tag_addr = flush_cnt_q;
        flush_cnt_d      = flush_cnt_q + IDX'(1);
        if (flush_cnt_q == IDX'(SETS - 1)) begin
          icu_ifu_flush_done = 1'b1;
          flush_pend_d       = 1'b0;
          state_d            = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset leaves a flush pending so the tags are cleared first
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      flush_pend_q <= 1'b1;
      rr_q         <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      line_fault_q <= 1'b0;
      cancel_q     <= 1'b0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
      rr_q         <= rr_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
      line_fault_q <= line_fault_d;
      cancel_q     <= cancel_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_icu_nway_ctrl.sv
// Directed bench for icu_nway_ctrl: the stimulus pushes expected RAM writes and responses; monitors pop and compare them.
module tb_icu_nway_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned IX = 7;
  localparam int unsigned TW = 21;

  logic                clk;
  logic                resetn;
  logic                ifu_icu_req_ic1;
  logic [31:3]         ifu_icu_addr_ic1;
  logic                icu_ifu_ack_ic1;
  logic                ifu_icu_cancel;
  logic                ifu_icu_flush;
  logic                icu_ifu_flush_done;
  logic                icu_ifu_data_valid_ic2;
  logic [63:0]         icu_ifu_data_ic2;
  logic                icu_ifu_fault_ic2;
  logic [W-1:0]        icu_ram_tag_en;
  logic                icu_ram_tag_wr;
  logic [IX-1:0]       icu_ram_tag_addr;
  logic [TW-1:0]       icu_ram_tag_wdata;
  logic [W*TW-1:0]     ram_icu_tag_rdata;
  logic [W-1:0]        icu_ram_data_en;
  logic                icu_ram_data_wr;
  logic [IX+1:0]       icu_ram_data_addr;
  logic [63:0]         icu_ram_data_wdata;
  logic [W*64-1:0]     ram_icu_data_rdata;
  logic                icu_biu_req;
  logic [31:3]         icu_biu_addr;
  logic                icu_biu_single;
  logic                biu_icu_ack;
  logic                biu_icu_data_valid;
  logic                biu_icu_data_last;
  logic                biu_icu_fault;
  logic [63:0]         biu_icu_data;

  icu_nway_ctrl #(.WAYS(W), .IDX(IX), .BEATS(4)) dut (
    .clk(clk), .resetn(resetn),
    .ifu_icu_req_ic1(ifu_icu_req_ic1), .ifu_icu_addr_ic1(ifu_icu_addr_ic1),
    .icu_ifu_ack_ic1(icu_ifu_ack_ic1), .ifu_icu_cancel(ifu_icu_cancel),
    .ifu_icu_flush(ifu_icu_flush), .icu_ifu_flush_done(icu_ifu_flush_done),
    .icu_ifu_data_valid_ic2(icu_ifu_data_valid_ic2), .icu_ifu_data_ic2(icu_ifu_data_ic2),
    .icu_ifu_fault_ic2(icu_ifu_fault_ic2),
    .icu_ram_tag_en(icu_ram_tag_en), .icu_ram_tag_wr(icu_ram_tag_wr),
    .icu_ram_tag_addr(icu_ram_tag_addr), .icu_ram_tag_wdata(icu_ram_tag_wdata),
    .ram_icu_tag_rdata(ram_icu_tag_rdata),
    .icu_ram_data_en(icu_ram_data_en), .icu_ram_data_wr(icu_ram_data_wr),
    .icu_ram_data_addr(icu_ram_data_addr), .icu_ram_data_wdata(icu_ram_data_wdata),
    .ram_icu_data_rdata(ram_icu_data_rdata),
    .icu_biu_req(icu_biu_req), .icu_biu_addr(icu_biu_addr), .icu_biu_single(icu_biu_single),
    .biu_icu_ack(biu_icu_ack), .biu_icu_data_valid(biu_icu_data_valid),
    .biu_icu_data_last(biu_icu_data_last), .biu_icu_fault(biu_icu_fault),
    .biu_icu_data(biu_icu_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural tag/data RAMs with 1-cycle read latency
  logic [TW-1:0] tag_mem [W][2**IX];
  logic [63:0]   dat_mem [W][2**(IX+2)];
  always @(posedge clk) begin
    for (int w = 0; w < W; w++) begin
      if (icu_ram_tag_en[w]) begin
        if (icu_ram_tag_wr) tag_mem[w][icu_ram_tag_addr] <= icu_ram_tag_wdata;
        else ram_icu_tag_rdata[w*TW +: TW] <= tag_mem[w][icu_ram_tag_addr];
      end
      if (icu_ram_data_en[w]) begin
        if (icu_ram_data_wr) dat_mem[w][icu_ram_data_addr] <= icu_ram_data_wdata;
        else ram_icu_data_rdata[w*64 +: 64] <= dat_mem[w][icu_ram_data_addr];
      end
    end
  end

  int tests;
  int fails;
  logic [64:0] rsp_q [$];
  logic [31:0] tag_q [$];
  logic [76:0] dat_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_addr(input logic [19:0] tag, input logic [6:0] idx, input logic [1:0] b);
    return {tag, idx, b, 3'b000};
  endfunction

  function automatic logic [63:0] dpat(input logic [19:0] tag, input logic [1:0] b);
    return {16'hCAFE, 12'h000, tag, 14'h0000, b};
  endfunction

  // Monitors: pop the expected item whenever the DUT presents a response or a RAM write
  logic [64:0] exp_r;
  logic [31:0] exp_t;
  logic [76:0] exp_d;
  always @(negedge clk) begin
    if (resetn) begin
      if (icu_ifu_data_valid_ic2) begin
        if (rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_response: got %0h fault %b want none", icu_ifu_data_ic2, icu_ifu_fault_ic2);
        end else begin
          exp_r = rsp_q.pop_front();
          chk("response", {icu_ifu_fault_ic2, icu_ifu_data_ic2}, exp_r);
        end
      end
      if (icu_ram_tag_wr && (icu_ram_tag_en != '0)) begin
        if (tag_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_tag_write: got addr %0h en %b wdata %0h", icu_ram_tag_addr, icu_ram_tag_en, icu_ram_tag_wdata);
        end else begin
          exp_t = tag_q.pop_front();
          chk("tag_write", {icu_ram_tag_addr, icu_ram_tag_en, icu_ram_tag_wdata}, exp_t);
        end
      end
      if (icu_ram_data_wr && (icu_ram_data_en != '0)) begin
        if (dat_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_data_write: got addr %0h en %b", icu_ram_data_addr, icu_ram_data_en);
        end else begin
          exp_d = dat_q.pop_front();
          chk("data_write", {icu_ram_data_addr, icu_ram_data_en, icu_ram_data_wdata}, exp_d);
        end
      end
    end
  end

  task automatic push_flush();
    for (int i = 0; i < 128; i++) tag_q.push_back({7'(i), 4'hF, 21'h0});
  endtask

  task automatic push_fill(input logic [19:0] tag, input logic [6:0] idx, input int way, input logic v,
                           input logic [1:0] rbeat, input logic rfault, input logic with_rsp);
    for (int b = 0; b < 4; b++) dat_q.push_back({idx, 2'(b), 4'(1 << way), dpat(tag, 2'(b))});
    tag_q.push_back({idx, 4'(1 << way), v, tag});
    if (with_rsp) rsp_q.push_back({rfault, dpat(tag, rbeat)});
  endtask

  // Issue one fetch; checks the lookup-cycle outcome one cycle after acceptance
  task automatic fetch(input logic [31:0] a, input logic exp_hit);
    int n;
    ifu_icu_req_ic1 = 1'b1;
    ifu_icu_addr_ic1 = a[31:3];
    #1;
    n = 0;
    while (!icu_ifu_ack_ic1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!icu_ifu_ack_ic1) begin
      chk("ack_timeout", 0, 1);
      ifu_icu_req_ic1 = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ifu_icu_req_ic1 = 1'b0;
    @(negedge clk);
    chk(exp_hit ? "hit_next_cycle" : "miss_no_data", icu_ifu_data_valid_ic2, exp_hit);
    if (!exp_hit) chk("miss_no_early_biu_req", icu_biu_req, 0);
  endtask

  // BIU side of a linefill: ack the request, then four back-to-back beats
  task automatic bfm_fill(input logic [19:0] tag, input logic [6:0] idx, input int fault_beat,
                          input int flush_beat, input int exp_lat);
    int n;
    n = 0;
    while (!icu_biu_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!icu_biu_req) begin
      chk("biu_req_timeout", 0, 1);
      return;
    end
    if (exp_lat >= 0) chk("biu_req_latency", n, exp_lat);
    chk("biu_addr", icu_biu_addr, {tag, idx, 2'b00});
    biu_icu_ack = 1'b1;
    @(posedge clk);
    #1 biu_icu_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      biu_icu_data_valid = 1'b1;
      biu_icu_data       = dpat(tag, 2'(b));
      biu_icu_data_last  = (b == 3);
      biu_icu_fault      = (b == fault_beat);
      ifu_icu_flush      = (b == flush_beat);
      @(posedge clk);
      #1;
    end
    biu_icu_data_valid = 1'b0;
    biu_icu_data_last  = 1'b0;
    biu_icu_fault      = 1'b0;
    biu_icu_data       = '0;
    ifu_icu_flush      = 1'b0;
  endtask

  // With req held high: no ack until flush_done, then ack on the very next cycle (which misses)
  task automatic wait_flush_then_ack();
    int n, done_cnt, done_cyc, ack_cyc, early, wr_cnt;
    n = 0; done_cnt = 0; done_cyc = -10; ack_cyc = -1; early = 0; wr_cnt = 0;
    while (n < 400) begin
      @(negedge clk);
      if (icu_ram_tag_wr && (icu_ram_tag_en == 4'hF)) wr_cnt++;
      if (icu_ifu_ack_ic1) begin
        if (done_cnt == 0) early++;
        else begin
          ack_cyc = n;
          break;
        end
      end
      if (icu_ifu_flush_done) begin
        done_cnt++;
        done_cyc = n;
      end
      n++;
    end
    chk("no_ack_during_flush", early, 0);
    chk("flush_done_pulses", done_cnt, 1);
    chk("flush_tag_writes", wr_cnt, 128);
    chk("ack_after_flush_done", ack_cyc, done_cyc + 1);
    @(posedge clk);
    #1 ifu_icu_req_ic1 = 1'b0;
    @(negedge clk);
    chk("post_flush_miss", icu_ifu_data_valid_ic2, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tests = 0; fails = 0;
    resetn = 1'b0;
    ifu_icu_cancel = 1'b0; ifu_icu_flush = 1'b0;
    biu_icu_ack = 1'b0; biu_icu_data_valid = 1'b0; biu_icu_data_last = 1'b0;
    biu_icu_fault = 1'b0; biu_icu_data = '0;
    ifu_icu_req_ic1 = 1'b1;
    ifu_icu_addr_ic1 = mk_addr(20'h00100, 7'd5, 2'd1) >> 3;
    push_flush();
    repeat (2) @(negedge clk);
    chk("rst_ack", icu_ifu_ack_ic1, 0);
    chk("rst_data_valid", icu_ifu_data_valid_ic2, 0);
    chk("rst_tag_en", icu_ram_tag_en, 0);
    chk("rst_data_en", icu_ram_data_en, 0);
    chk("rst_biu_req", icu_biu_req, 0);
    chk("rst_flush_done", icu_ifu_flush_done, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    wait_flush_then_ack();

    // Five tags into set 5: ways 0..3 by invalid-first, fifth evicts rr way 0
    push_fill(20'h00100, 7'd5, 0, 1'b1, 2'd1, 1'b0, 1'b1);
    bfm_fill(20'h00100, 7'd5, -1, -1, 1);
    for (int t = 1; t < 5; t++) begin
      push_fill(20'h00100 + 20'(t), 7'd5, t % 4, 1'b1, 2'd1, 1'b0, 1'b1);
      fetch(mk_addr(20'h00100 + 20'(t), 7'd5, 2'd1), 1'b0);
      bfm_fill(20'h00100 + 20'(t), 7'd5, -1, -1, 1);
    end
    for (int t = 1; t < 5; t++) begin
      rsp_q.push_back({1'b0, dpat(20'h00100 + 20'(t), 2'd1)});
      fetch(mk_addr(20'h00100 + 20'(t), 7'd5, 2'd1), 1'b1);
    end
    // Evicted tag 0x100 returns: set full, rr counter is now 1
    push_fill(20'h00100, 7'd5, 1, 1'b1, 2'd1, 1'b0, 1'b1);
    fetch(mk_addr(20'h00100, 7'd5, 2'd1), 1'b0);
    bfm_fill(20'h00100, 7'd5, -1, -1, 1);
    rsp_q.push_back({1'b0, dpat(20'h00102, 2'd1)});
    fetch(mk_addr(20'h00102, 7'd5, 2'd1), 1'b1);

    // Cold fetch 0x1000_0010: set 0, beat 2, way 0
    push_fill(20'h10000, 7'd0, 0, 1'b1, 2'd2, 1'b0, 1'b1);
    fetch(32'h1000_0010, 1'b0);
    bfm_fill(20'h10000, 7'd0, -1, -1, 1);
    rsp_q.push_back({1'b0, dpat(20'h10000, 2'd2)});
    fetch(32'h1000_0010, 1'b1);

    // Faulting fills leave the line invalid
    push_fill(20'h00200, 7'd9, 0, 1'b0, 2'd0, 1'b0, 1'b1);
    fetch(mk_addr(20'h00200, 7'd9, 2'd0), 1'b0);
    bfm_fill(20'h00200, 7'd9, 1, -1, 1);
    push_fill(20'h00200, 7'd9, 0, 1'b0, 2'd0, 1'b1, 1'b1);
    fetch(mk_addr(20'h00200, 7'd9, 2'd0), 1'b0);
    bfm_fill(20'h00200, 7'd9, 0, -1, 1);
    push_fill(20'h00200, 7'd9, 0, 1'b1, 2'd0, 1'b0, 1'b1);
    fetch(mk_addr(20'h00200, 7'd9, 2'd0), 1'b0);
    bfm_fill(20'h00200, 7'd9, -1, -1, 1);
    rsp_q.push_back({1'b0, dpat(20'h00200, 2'd0)});
    fetch(mk_addr(20'h00200, 7'd9, 2'd0), 1'b1);

    // Cancel during MISS: no response, line still installed
    push_fill(20'h00300, 7'd12, 0, 1'b1, 2'd3, 1'b0, 1'b0);
    fetch(mk_addr(20'h00300, 7'd12, 2'd3), 1'b0);
    @(posedge clk);
    #1 ifu_icu_cancel = 1'b1;
    @(posedge clk);
    #1 ifu_icu_cancel = 1'b0;
    bfm_fill(20'h00300, 7'd12, -1, -1, 0);
    rsp_q.push_back({1'b0, dpat(20'h00300, 2'd3)});
    fetch(mk_addr(20'h00300, 7'd12, 2'd3), 1'b1);

    // Flush during FILL: the fill completes, then a full flush, then the old line misses
    push_fill(20'h00400, 7'd20, 0, 1'b1, 2'd1, 1'b0, 1'b1);
    push_flush();
    fetch(mk_addr(20'h00400, 7'd20, 2'd1), 1'b0);
    bfm_fill(20'h00400, 7'd20, -1, 2, 1);
    ifu_icu_req_ic1 = 1'b1;
    ifu_icu_addr_ic1 = mk_addr(20'h00300, 7'd12, 2'd3) >> 3;
    wait_flush_then_ack();
    push_fill(20'h00300, 7'd12, 0, 1'b1, 2'd3, 1'b0, 1'b1);
    bfm_fill(20'h00300, 7'd12, -1, -1, 1);

    n = 0;
    while ((rsp_q.size() != 0 || tag_q.size() != 0 || dat_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("responses_left", rsp_q.size(), 0);
    chk("tag_writes_left", tag_q.size(), 0);
    chk("data_writes_left", dat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
